// File: rtl/exception_controller.sv
`timescale 1ns/1ps
// Exception controller: latches MemFault/InvalidOp/ExtIRQ causes and runs a
// request/ack/return handshake. Define EXC_CTRL_TIMEOUT_EN for the ExcAck timeout.
module exception_controller #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ExtIRQ,
   input  logic       InvalidOp,
   input  logic       MemFault,
   input  logic       IrqMask,
   input  logic       ExcAck,
   input  logic       ERet,
   output logic       Exc,
   output logic [3:0] EStatus,
   output logic       Busy,
   output logic       Overrun,
   output logic       AckTimeout
);

   // Cause index i reports cause code i+1: 0 = ExtIRQ, 1 = InvalidOp, 2 = MemFault.
   localparam int NUM_CAUSES = 3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_SERVICE
   } state_t;

   state_t                state_reg;
   logic                  irq_meta_reg;
   logic                  irq_sync_reg;
   logic                  irq_last_reg;
   logic                  irq_rise;
   logic [NUM_CAUSES-1:0] event_vec;
   logic [NUM_CAUSES-1:0] pend_reg;
   logic [NUM_CAUSES-1:0] pend_next;
   logic [NUM_CAUSES-1:0] eligible;
   logic [NUM_CAUSES-1:0] grant;
   logic [NUM_CAUSES-1:0] consume;
   logic [NUM_CAUSES-1:0] requeue;
   logic [NUM_CAUSES-1:0] overrun_hit;
   logic [3:0]            win_code;
   logic                  timeout_fire;
   logic                  exc_reg;
   logic [3:0]            estatus_reg;
   logic                  busy_reg;
   logic                  overrun_reg;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 1..255");
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irq_meta_reg <= 1'b0;
         irq_sync_reg <= 1'b0;
         irq_last_reg <= 1'b0;
      end else begin
         irq_meta_reg <= ExtIRQ;
         irq_sync_reg <= irq_meta_reg;
         irq_last_reg <= irq_sync_reg;
      end
   end

   assign irq_rise  = irq_sync_reg & ~irq_last_reg;
   assign event_vec = {MemFault, InvalidOp, irq_rise};
   // A masked ExtIRQ stays latched; it is only kept out of arbitration.
   assign eligible  = (pend_reg | event_vec) & {2'b11, ~IrqMask};

   always_comb begin
      grant    = '0;
      win_code = 4'b0000;
      if (eligible[2]) begin
         grant[2] = 1'b1;
         win_code = 4'b0011;
      end else if (eligible[1]) begin
         grant[1] = 1'b1;
         win_code = 4'b0010;
      end else if (eligible[0]) begin
         grant[0] = 1'b1;
         win_code = 4'b0001;
      end
   end

   assign consume = (state_reg == ST_IDLE) ? grant : '0;

   // A consumed cause stays pending only if it was already pending and a fresh
   // event of the same kind arrives in the same cycle.
   for (genvar gi = 0; gi < NUM_CAUSES; gi++) begin : g_cause
      assign requeue[gi]     = timeout_fire && (estatus_reg == 4'(gi + 1));
      assign overrun_hit[gi] = event_vec[gi] & pend_reg[gi];
      assign pend_next[gi]   = consume[gi] ? (pend_reg[gi] & event_vec[gi])
                                           : (pend_reg[gi] | event_vec[gi] | requeue[gi]);
   end

`ifdef EXC_CTRL_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] tmo_cnt_reg;
   logic       ack_timeout_reg;

   assign timeout_fire = (state_reg == ST_REQ) && !ExcAck && (tmo_cnt_reg == TMO_LAST);

   // Counter is zero on the first REQ cycle because it idles at zero outside REQ.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tmo_cnt_reg     <= 8'd0;
         ack_timeout_reg <= 1'b0;
      end else begin
         ack_timeout_reg <= timeout_fire;
         if (state_reg == ST_REQ && !timeout_fire)
            tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
         else
            tmo_cnt_reg <= 8'd0;
      end
   end

   assign AckTimeout = ack_timeout_reg;
`else
   assign timeout_fire = 1'b0;
   assign AckTimeout   = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= ST_IDLE;
         pend_reg    <= '0;
         exc_reg     <= 1'b0;
         estatus_reg <= 4'b0000;
         busy_reg    <= 1'b0;
         overrun_reg <= 1'b0;
      end else begin
         pend_reg <= pend_next;
         if (|overrun_hit)
            overrun_reg <= 1'b1;
         case (state_reg)
            ST_IDLE: begin
               if (|grant) begin
                  state_reg   <= ST_REQ;
                  exc_reg     <= 1'b1;
                  estatus_reg <= win_code;
               end
            end
            ST_REQ: begin
               if (ExcAck) begin
                  state_reg <= ST_SERVICE;
                  exc_reg   <= 1'b0;
                  busy_reg  <= 1'b1;
               end else if (timeout_fire) begin
                  state_reg <= ST_IDLE;
                  exc_reg   <= 1'b0;
               end
            end
            ST_SERVICE: begin
               if (ERet) begin
                  state_reg <= ST_IDLE;
                  busy_reg  <= 1'b0;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign Exc     = exc_reg;
   assign EStatus = estatus_reg;
   assign Busy    = busy_reg;
   assign Overrun = overrun_reg;

endmodule

// File: doc/exception_controller.md
EXCEPTION_CONTROLLER -- requirements
Module: exception_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: ExcAck wait limit in cycles, range 1..255; used only under REQ-030.
REQ-002 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ExtIRQ  input  1  external interrupt, level, asynchronous to clk.
REQ-005 SHALL have port InvalidOp  input  1  one-cycle pulse from decode, invalid opcode.
REQ-006 SHALL have port MemFault  input  1  one-cycle pulse from memory stage, access fault.
REQ-007 SHALL have port IrqMask  input  1  1 = ExtIRQ excluded from arbitration.
REQ-008 SHALL have port ExcAck  input  1  vector fetch acknowledged by exception unit.
REQ-009 SHALL have port ERet  input  1  handler return executed.
REQ-010 SHALL have port Exc  output  1  exception request to exception unit.
REQ-011 SHALL have port EStatus  output  4  cause code of the current request.
REQ-012 SHALL have port Busy  output  1  handler in service.
REQ-013 SHALL have port Overrun  output  1  sticky lost-event flag.
REQ-014 SHALL have port AckTimeout  output  1  one-cycle timeout pulse.

Function
REQ-015 SHALL pass ExtIRQ through a 2-flop synchronizer and set pend_irq on the synchronized rising edge only.
REQ-016 SHALL set pend_mem on MemFault=1 and pend_inv on InvalidOp=1 at the sampling edge.
REQ-017 SHALL arbitrate (pending | same-cycle events) with priority MemFault > InvalidOp > ExtIRQ, ExtIRQ excluded while IrqMask=1 (still latched).
REQ-018 SHALL encode EStatus: MemFault 4'b0011, InvalidOp 4'b0010, ExtIRQ 4'b0001.
REQ-019 SHALL implement FSM IDLE, REQ, SERVICE, all outputs registered.
REQ-020 IDLE: any eligible cause -> REQ at next edge; Exc=1, EStatus=winning code, winner's pending bit cleared; latency 1 cycle from pulse, 3 cycles from ExtIRQ rise.
REQ-021 REQ: Exc held 1 until ExcAck=1; then -> SERVICE, Exc=0, Busy=1.
REQ-022 SERVICE: events keep accumulating; ERet=1 -> IDLE, Busy=0; next pending cause arbitrated in IDLE the following cycle.
REQ-023 EStatus SHALL stay stable from REQ entry until the next REQ entry.
REQ-024 ERet SHALL be ignored in IDLE and REQ; ExcAck SHALL be ignored in IDLE and SERVICE.
REQ-025 Set and clear of the same pending bit in one cycle: set wins.
REQ-026 Event arriving while its pending bit is already 1: SHALL set Overrun (sticky, cleared only by reset); event counted once.

Reset
REQ-027 reset=0 SHALL asynchronously force IDLE, pending bits 0, synchronizer 0, Exc=0, EStatus=4'b0000, Busy=0, Overrun=0, AckTimeout=0.
REQ-028 Reset asserted mid-REQ or mid-SERVICE SHALL discard the in-flight exception and all pending causes.
REQ-029 After reset deassertion, events SHALL be sampled from the first rising edge.

Configuration
REQ-030 With EXC_CTRL_TIMEOUT_EN defined: 8-bit counter in REQ; ExcAck absent TIMEOUT_CYCLES cycles -> Exc=0, return to IDLE, cause's pending bit re-set, AckTimeout=1 for one cycle; counter cleared on REQ entry.
REQ-031 Without EXC_CTRL_TIMEOUT_EN: REQ waits indefinitely; AckTimeout tied 0; no counter logic.

Verification
REQ-032 InvalidOp pulse cycle 0, ExcAck cycle 3, ERet cycle 10 -> Exc=1 cycles 1-3, EStatus=4'b0010, Busy=1 cycles 4-10, Busy=0 cycle 11.
REQ-033 MemFault and InvalidOp same cycle -> first EStatus=4'b0011; after ERet, second request EStatus=4'b0010.
REQ-034 ExtIRQ high with IrqMask=1 for 20 cycles -> Exc stays 0; IrqMask dropped -> Exc=1 next cycle, EStatus=4'b0001.
REQ-035 Second InvalidOp during SERVICE while pend_inv already 1 -> Overrun=1, remains 1 until reset.
REQ-036 Macro defined, TIMEOUT_CYCLES=4, no ExcAck -> Exc falls after 4 cycles in REQ, AckTimeout 1-cycle pulse, re-request next cycle same EStatus; reset=0 mid-SERVICE -> all outputs 0 immediately.
